// File: rtl/dmem_access_unit.sv
// ============================================================================
// Module   : dmem_access_unit
// Brief    : MEM-stage data-memory access FSM (IDLE/REQ/DONE) with pipeline
//            stall, misalignment detection and optional REQ timeout
//            (enabled by defining DMEM_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    input  logic [31:0] ALU_result_i,
    input  logic [31:0] Mem_Write_Data_i,
    input  logic [4:0]  Write_register_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic [4:0]  Write_register_o,
    output logic [31:0] ALU_result_o,
    output logic [31:0] Read_data_o,
    output logic        misalign_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("dmem_access_unit: TIMEOUT must be at least 1");
    end

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic w_access;
    logic w_aligned;
    logic w_start;

    assign w_access  = MemRead_i | MemWrite_i;
    assign w_aligned = (ALU_result_i[1:0] == 2'b00);
    assign w_start   = (r_state == S_IDLE) && w_access && w_aligned;

    assign misalign_o       = (r_state == S_IDLE) && w_access && !w_aligned;
    assign stall_o          = w_start || (r_state == S_REQ);
    // Dropping RegWrite while stalled turns the held instruction into a MEM/WB bubble
    assign RegWrite_o       = RegWrite_i & ~stall_o & ~misalign_o;
    assign MemtoReg_o       = MemtoReg_i;
    assign Write_register_o = Write_register_i;
    assign ALU_result_o     = ALU_result_i;

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign Read_data_o = r_rdata;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign err_o = r_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_err <= 1'b0;
                    if (w_start) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_i;
                        r_addr  <= ALU_result_i;
                        r_wdata <= Mem_Write_Data_i;
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_rdata <= r_we ? 32'd0 : mem_rdata_i;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign err_o = 1'b0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_i;
                        r_addr  <= ALU_result_i;
                        r_wdata <= Mem_Write_Data_i;
                    end
                end
                S_REQ: begin
                    // A read+write combination is performed as a write, so no read data returns
                    if (mem_ack_i) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_rdata <= r_we ? 32'd0 : mem_rdata_i;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// ============================================================================
// Module   : tb_dmem_access_unit
// Brief    : Directed self-checking bench for dmem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic        MemtoReg_i = 1'b0;
    logic        RegWrite_i = 1'b0;
    logic [31:0] ALU_result_i = 32'd0;
    logic [31:0] Mem_Write_Data_i = 32'd0;
    logic [4:0]  Write_register_i = 5'd0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        stall_o;
    logic        MemtoReg_o;
    logic        RegWrite_o;
    logic [4:0]  Write_register_o;
    logic [31:0] ALU_result_o;
    logic [31:0] Read_data_o;
    logic        misalign_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    dmem_access_unit #(.TIMEOUT(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .MemRead_i        (MemRead_i),
        .MemWrite_i       (MemWrite_i),
        .MemtoReg_i       (MemtoReg_i),
        .RegWrite_i       (RegWrite_i),
        .ALU_result_i     (ALU_result_i),
        .Mem_Write_Data_i (Mem_Write_Data_i),
        .Write_register_i (Write_register_i),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i),
        .stall_o          (stall_o),
        .MemtoReg_o       (MemtoReg_o),
        .RegWrite_o       (RegWrite_o),
        .Write_register_o (Write_register_o),
        .ALU_result_o     (ALU_result_o),
        .Read_data_o      (Read_data_o),
        .misalign_o       (misalign_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_i    = 1'b0;
        MemWrite_i   = 1'b0;
        RegWrite_i   = 1'b0;
        MemtoReg_i   = 1'b0;
        mem_ack_i    = 1'b0;
        ALU_result_i = 32'd0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
        n_checks++; if (mem_we_o !== 1'b0) begin n_errors++; $display("FAIL rst_we: got %b want 0", mem_we_o); end
        n_checks++; if (mem_addr_o !== 32'd0) begin n_errors++; $display("FAIL rst_addr: got %h want 0", mem_addr_o); end
        n_checks++; if (mem_wdata_o !== 32'd0) begin n_errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata_o); end
        n_checks++; if (Read_data_o !== 32'd0) begin n_errors++; $display("FAIL rst_rdata: got %h want 0", Read_data_o); end
        n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b want 0", err_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b want 0", stall_o); end
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int stalls = 0;
        MemRead_i = 1'b1; RegWrite_i = 1'b1; MemtoReg_i = 1'b1;
        ALU_result_i = 32'h40; Write_register_i = 5'd7;
        @(negedge clk_i);
        stalls += int'(stall_o);
        n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL load_idle_stall: got %b want 1", stall_o); end
        n_checks++; if (RegWrite_o !== 1'b0) begin n_errors++; $display("FAIL load_idle_regwr: got %b want 0", RegWrite_o); end
        n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL load_idle_req: got %b want 0", mem_req_o); end
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        stalls += int'(stall_o);
        n_checks++; if (mem_req_o !== 1'b1) begin n_errors++; $display("FAIL load_req: got %b want 1", mem_req_o); end
        n_checks++; if (mem_addr_o !== 32'h40) begin n_errors++; $display("FAIL load_addr: got %h want 00000040", mem_addr_o); end
        n_checks++; if (mem_we_o !== 1'b0) begin n_errors++; $display("FAIL load_we: got %b want 0", mem_we_o); end
        n_checks++; if (RegWrite_o !== 1'b0) begin n_errors++; $display("FAIL load_req_regwr: got %b want 0", RegWrite_o); end
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        stalls += int'(stall_o);
        n_checks++; if (Read_data_o !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load_rdata: got %h want deadbeef", Read_data_o); end
        n_checks++; if (RegWrite_o !== 1'b1) begin n_errors++; $display("FAIL load_done_regwr: got %b want 1", RegWrite_o); end
        n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL load_done_req: got %b want 0", mem_req_o); end
        n_checks++; if (stalls != 2) begin n_errors++; $display("FAIL load_stall_cycles: got %0d want 2", stalls); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_store();
        int stalls = 0;
        MemWrite_i = 1'b1; ALU_result_i = 32'h44; Mem_Write_Data_i = 32'h12345678;
        @(negedge clk_i);
        stalls += int'(stall_o);
        for (int k = 1; k <= 3; k++) begin
            tick();
            Mem_Write_Data_i = 32'hFFFF0000 + k;
            ALU_result_i     = 32'h44;
            mem_ack_i        = (k == 3);
            mem_rdata_i      = 32'hA5A5A5A5;
            @(negedge clk_i);
            stalls += int'(stall_o);
            n_checks++; if (mem_wdata_o !== 32'h12345678) begin n_errors++; $display("FAIL store_wdata_%0d: got %h want 12345678", k, mem_wdata_o); end
            n_checks++; if ({mem_req_o, mem_we_o} !== 2'b11) begin n_errors++; $display("FAIL store_req_we_%0d: got %b want 11", k, {mem_req_o, mem_we_o}); end
        end
        n_checks++; if (mem_addr_o !== 32'h44) begin n_errors++; $display("FAIL store_addr: got %h want 00000044", mem_addr_o); end
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        stalls += int'(stall_o);
        n_checks++; if (Read_data_o !== 32'd0) begin n_errors++; $display("FAIL store_rdata: got %h want 0", Read_data_o); end
        n_checks++; if (stalls != 4) begin n_errors++; $display("FAIL store_stall_cycles: got %0d want 4", stalls); end
        n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL store_err: got %b want 0", err_o); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_read_write();
        // Preload a nonzero read result so a zero afterwards is meaningful
        MemRead_i = 1'b1; ALU_result_i = 32'h4C;
        tick(); mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        tick(); mem_ack_i = 1'b0;
        tick();
        MemWrite_i = 1'b1; ALU_result_i = 32'h48; Mem_Write_Data_i = 32'h55AA55AA;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        @(negedge clk_i);
        n_checks++; if (mem_we_o !== 1'b1) begin n_errors++; $display("FAIL rw_we: got %b want 1", mem_we_o); end
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (Read_data_o !== 32'd0) begin n_errors++; $display("FAIL rw_rdata: got %h want 0", Read_data_o); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_misalign();
        MemRead_i = 1'b1; RegWrite_i = 1'b1; ALU_result_i = 32'h41;
        @(negedge clk_i);
        n_checks++; if (misalign_o !== 1'b1) begin n_errors++; $display("FAIL mis_flag: got %b want 1", misalign_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL mis_stall: got %b want 0", stall_o); end
        n_checks++; if (RegWrite_o !== 1'b0) begin n_errors++; $display("FAIL mis_regwr: got %b want 0", RegWrite_o); end
        tick();
        MemRead_i = 1'b0; MemtoReg_i = 1'b0; ALU_result_i = 32'h100; Write_register_i = 5'd19;
        @(negedge clk_i);
        n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL mis_req: got %b want 0", mem_req_o); end
        n_checks++; if (misalign_o !== 1'b0) begin n_errors++; $display("FAIL alu_misflag: got %b want 0", misalign_o); end
        n_checks++; if ({stall_o, RegWrite_o} !== 2'b01) begin n_errors++; $display("FAIL alu_stall_regwr: got %b want 01", {stall_o, RegWrite_o}); end
        n_checks++; if (ALU_result_o !== 32'h100) begin n_errors++; $display("FAIL alu_pass: got %h want 00000100", ALU_result_o); end
        n_checks++; if (Write_register_o !== 5'd19) begin n_errors++; $display("FAIL wreg_pass: got %0d want 19", Write_register_o); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        MemRead_i = 1'b1; ALU_result_i = 32'h50;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
        tick();
        mem_rdata_i = 32'hBAD0BAD0;
        @(negedge clk_i);
        n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL b2b_done_req: got %b want 0", mem_req_o); end
        tick();
        mem_ack_i = 1'b0; ALU_result_i = 32'h54;
        @(negedge clk_i);
        n_checks++; if ({stall_o, mem_req_o} !== 2'b10) begin n_errors++; $display("FAIL b2b_idle2: got %b want 10", {stall_o, mem_req_o}); end
        n_checks++; if (Read_data_o !== 32'h11111111) begin n_errors++; $display("FAIL b2b_ack_ignored: got %h want 11111111", Read_data_o); end
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h22223333;
        @(negedge clk_i);
        n_checks++; if (mem_addr_o !== 32'h54 || mem_req_o !== 1'b1) begin n_errors++; $display("FAIL b2b_req2: got req=%b addr=%h want req=1 addr=00000054", mem_req_o, mem_addr_o); end
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (Read_data_o !== 32'h22223333) begin n_errors++; $display("FAIL b2b_rdata2: got %h want 22223333", Read_data_o); end
        tick();
        idle_inputs();
        @(negedge clk_i);
        n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL b2b_no_dup: got %b want 0", mem_req_o); end
        tick();
    endtask

    task automatic test_reset_in_req();
        MemRead_i = 1'b1; ALU_result_i = 32'h60;
        tick();
        tick();
        rst_i = 1'b0;
        MemRead_i = 1'b0;
        #1;
        n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL rreq_req: got %b want 0", mem_req_o); end
        n_checks++; if (Read_data_o !== 32'd0) begin n_errors++; $display("FAIL rreq_rdata: got %h want 0", Read_data_o); end
        tick();
        rst_i = 1'b1;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
        @(negedge clk_i);
        n_checks++; if ({mem_req_o, stall_o} !== 2'b00) begin n_errors++; $display("FAIL rreq_idle: got %b want 00", {mem_req_o, stall_o}); end
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (Read_data_o !== 32'd0) begin n_errors++; $display("FAIL rreq_ack_ignored: got %h want 0", Read_data_o); end
        tick();
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles = 0;
        int err_cycles = 0;
        MemRead_i = 1'b1; ALU_result_i = 32'h70;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) MemRead_i = 1'b1;
            @(negedge clk_i);
            req_cycles += int'(mem_req_o);
            if (err_o === 1'b1) begin
                err_cycles++;
                n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL to_stall: got %b want 0", stall_o); end
                n_checks++; if (Read_data_o !== 32'd0) begin n_errors++; $display("FAIL to_rdata: got %h want 0", Read_data_o); end
                MemRead_i = 1'b0;
            end
        end
        n_checks++; if (req_cycles != 4) begin n_errors++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
        n_checks++; if (err_cycles != 1) begin n_errors++; $display("FAIL to_err_cycles: got %0d want 1", err_cycles); end
        idle_inputs();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_read_write();
        test_misalign();
        test_back_to_back();
        test_reset_in_req();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of REQ cycles to wait for mem_ack_i (used only with DMEM_TIMEOUT_EN).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i, input, 1 bit each: control bits from the EX/MEM register.
REQ-005 SHALL have ports ALU_result_i and Mem_Write_Data_i, input, 32 bits each: the access address and the store data.
REQ-006 SHALL have port Write_register_i, input, 5 bits: the destination register.
REQ-007 SHALL have ports mem_req_o and mem_we_o, output, 1 bit each: memory request and write enable.
REQ-008 SHALL have ports mem_addr_o and mem_wdata_o, output, 32 bits each: memory address and write data.
REQ-009 SHALL have ports mem_ack_i (input, 1 bit) and mem_rdata_i (input, 32 bits): memory completion and read data.
REQ-010 SHALL have port stall_o, output, 1 bit: when high, holds the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-011 SHALL have ports MemtoReg_o and RegWrite_o (output, 1 bit each), Write_register_o (output, 5 bits), ALU_result_o and Read_data_o (output, 32 bits each): the values toward MEM/WB.
REQ-012 SHALL have ports misalign_o and err_o, output, 1 bit each: alignment fault and timeout fault.

Function
REQ-013 SHALL implement FSM states IDLE, REQ and DONE, with reset state IDLE.
REQ-014 An access SHALL be defined as MemRead_i or MemWrite_i being high; it is aligned when ALU_result_i[1:0] is 00.
REQ-015 In IDLE with an aligned access, SHALL drive stall_o high combinationally and move to REQ on the next edge.
REQ-016 On entering REQ, SHALL register mem_addr_o = ALU_result_i, mem_wdata_o = Mem_Write_Data_i and mem_we_o = MemWrite_i.
REQ-017 SHALL hold mem_req_o high for every cycle spent in REQ and low in all other states.
REQ-018 When MemRead_i and MemWrite_i are both high, SHALL perform a write only and SHALL return Read_data_o = 0.
REQ-019 SHALL hold stall_o high for every cycle spent in REQ.
REQ-020 On mem_ack_i high in REQ, SHALL capture mem_rdata_i into Read_data_o for reads, or 0 for writes, and move to DONE.
REQ-021 Minimum access latency SHALL be 3 cycles (IDLE, REQ, DONE) when mem_ack_i arrives in the first REQ cycle.
REQ-022 In DONE, SHALL drive stall_o low, SHALL NOT start a new access, and SHALL return to IDLE on the next edge.
REQ-023 In IDLE, a misaligned access SHALL issue no request and no stall, SHALL drive misalign_o high combinationally for that cycle, and SHALL force RegWrite_o = 0.
REQ-024 In IDLE, a non-memory instruction SHALL pass through with zero added latency and no stall.
REQ-025 MemtoReg_o, Write_register_o and ALU_result_o SHALL equal their inputs combinationally.
REQ-026 RegWrite_o SHALL equal RegWrite_i AND NOT stall_o AND NOT misalign_o, which inserts a bubble into MEM/WB during a stall.
REQ-027 mem_ack_i SHALL be ignored in IDLE and DONE.
REQ-028 Register inputs SHALL be sampled only at REQ entry, so input changes during REQ have no effect.

Reset
REQ-029 While rst_i is low, SHALL set state = IDLE, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, Read_data_o = 0, err_o = 0 and the timeout counter = 0, asynchronously.
REQ-030 A reset asserted during REQ SHALL drop mem_req_o in the same cycle, and any later mem_ack_i SHALL be ignored.

Configuration
REQ-031 With DMEM_TIMEOUT_EN defined, SHALL count cycles in REQ; after TIMEOUT cycles without ack, SHALL drop mem_req_o, set Read_data_o = 0, move to DONE and pulse err_o high for the DONE cycle.
REQ-032 Without DMEM_TIMEOUT_EN, the REQ state SHALL wait indefinitely for mem_ack_i, and err_o SHALL be tied to 0.

Verification
REQ-033 Load: MemRead_i = 1, addr 0x40, ack in the first REQ cycle with rdata 0xDEADBEEF -> stall high for 2 cycles, Read_data_o = 0xDEADBEEF in DONE, RegWrite_o = 1 in DONE only.
REQ-034 Store: MemWrite_i = 1, addr 0x44, data 0x12345678, ack after 3 REQ cycles -> mem_we_o = 1, mem_addr_o = 0x44, mem_wdata_o = 0x12345678, stall high for 4 cycles, Read_data_o = 0.
REQ-035 Misaligned: MemRead_i = 1, addr 0x41 -> mem_req_o stays 0, stall_o = 0, misalign_o = 1 for one cycle, RegWrite_o = 0.
REQ-036 Back-to-back: two loads on consecutive instructions -> the second request starts in the cycle after DONE, with no lost or duplicated request.
REQ-037 Reset: rst_i driven low during REQ cycle 2, ack arriving 1 cycle after release -> mem_req_o = 0 immediately, state IDLE, Read_data_o = 0, ack ignored.
REQ-038 With DMEM_TIMEOUT_EN and TIMEOUT = 4, no ack -> mem_req_o high for exactly 4 cycles, then err_o = 1 for 1 cycle and stall_o released.
